// File: rtl/prbs23_checker_if.sv
// prbs23_checker_if: received-word stream, clear strobe and checker status
// bundled for connection between a word source (master) and the checker (slave).
`timescale 1ns/1ps

interface prbs23_checker_if;
  logic        clear;
  logic        in_valid;
  logic [22:0] in_data;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_words;
  logic [31:0] err_bits;

  modport master (
    output clear, in_valid, in_data,
    input  locked, err_pulse, err_words, err_bits
  );

  modport slave (
    input  clear, in_valid, in_data,
    output locked, err_pulse, err_words, err_bits
  );
endinterface

// File: rtl/prbs23_checker.sv
// prbs23_checker: word-parallel PRBS23 (x^23+x^18+1) receiver checker.
// Each accepted word is one full 23-bit generator state; the checker hunts for
// LOCK_CNT consecutive self-consistent words, then runs a free-running
// expected-word generator and counts word/bit errors until LOSS_CNT
// consecutive bad words drop it back to hunting.
// Optional build macro PRBS23_CHK_BITCNT_EN enables the err_bits popcount
// counter; without it err_bits is constant zero.
`timescale 1ns/1ps

module prbs23_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  prbs23_checker_if.slave  bus
);

  localparam int          DATA_W = 23;
  localparam logic [3:0]  LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0]  LOSS_N = 4'(LOSS_CNT);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  // One enable of a 23-bit-per-step generator: 23 single-bit LFSR shifts.
  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] t;
    t = s;
    for (int i = 0; i < DATA_W; i++) begin
      t = {t[18] ^ t[0], t[DATA_W-1:1]};
    end
    return t;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

`ifdef PRBS23_CHK_BITCNT_EN
  function automatic logic [4:0] popcount23(input logic [DATA_W-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [4:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {28'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
`endif

  state_t            state_q, state_d;
  logic              first_q, first_d;
  logic [3:0]        match_q, match_d;
  logic [3:0]        bad_q, bad_d;
  logic [DATA_W-1:0] ref_q, ref_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              err_pulse_p1, err_pulse_d;
  logic [15:0]       err_words_p1, err_words_d;
  logic [3:0]        match_inc;
  logic [3:0]        bad_inc;
`ifdef PRBS23_CHK_BITCNT_EN
  logic [31:0]       err_bits_p1, err_bits_d;
`endif

  assign match_inc = match_q + 4'd1;
  assign bad_inc   = bad_q + 4'd1;

  // Next-state, sync tracking and error accounting for the accepted word.
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    match_d     = match_q;
    bad_d       = bad_q;
    ref_d       = ref_q;
    exp_d       = exp_q;
    err_pulse_d = 1'b0;
    err_words_d = err_words_p1;
`ifdef PRBS23_CHK_BITCNT_EN
    err_bits_d  = err_bits_p1;
`endif
    if (bus.in_valid) begin
      unique case (state_q)
        HUNT: begin
          ref_d = bus.in_data;
          if (first_q) begin
            first_d = 1'b0;
            match_d = '0;
          end else if (bus.in_data == advance(ref_q) && bus.in_data != '0) begin
            if (match_inc == LOCK_N) begin
              state_d = LOCK;
              exp_d   = advance(bus.in_data);
              bad_d   = '0;
              match_d = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCK: begin
          exp_d = advance(exp_q);
          if (bus.in_data != exp_q) begin
            err_pulse_d = 1'b1;
            err_words_d = sat_inc16(err_words_p1);
`ifdef PRBS23_CHK_BITCNT_EN
            err_bits_d  = sat_add32(err_bits_p1, popcount23(bus.in_data ^ exp_q));
`endif
            if (bad_inc == LOSS_N) begin
              state_d = HUNT;
              match_d = '0;
              bad_d   = '0;
              ref_d   = bus.in_data;
            end else begin
              bad_d = bad_inc;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    // A clear on the same cycle as an error discards that word's count.
    if (bus.clear) begin
      err_words_d = '0;
`ifdef PRBS23_CHK_BITCNT_EN
      err_bits_d  = '0;
`endif
    end
  end

  // ---- stage p1: registered state and outputs ----
  // State, tracking registers and status outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      first_q      <= 1'b1;
      match_q      <= '0;
      bad_q        <= '0;
      ref_q        <= '0;
      exp_q        <= '0;
      err_pulse_p1 <= 1'b0;
      err_words_p1 <= '0;
`ifdef PRBS23_CHK_BITCNT_EN
      err_bits_p1  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      match_q      <= match_d;
      bad_q        <= bad_d;
      ref_q        <= ref_d;
      exp_q        <= exp_d;
      err_pulse_p1 <= err_pulse_d;
      err_words_p1 <= err_words_d;
`ifdef PRBS23_CHK_BITCNT_EN
      err_bits_p1  <= err_bits_d;
`endif
    end
  end

  assign bus.locked    = (state_q == LOCK);
  assign bus.err_pulse = err_pulse_p1;
  assign bus.err_words = err_words_p1;
`ifdef PRBS23_CHK_BITCNT_EN
  assign bus.err_bits  = err_bits_p1;
`else
  assign bus.err_bits  = '0;
`endif

endmodule
